burst_mem_responder: RTL and testbench
======================================

// Module: burst_mem_responder
// PURPOSE
//  Synthesizable physical-memory responder for the mp4 burst memory port.
//  Sits on the far side of mp4 pmem_*; serves 32-byte cachelines as 4 x 64-bit beats after a programmable latency.
//  Used for standalone CPU/cache simulation and FPGA bring-up; catches initiator protocol violations.
// PARAMETERS
//  DATA_W      64   beat width (bits)
//  BURST_LEN   4    beats per line (line = DATA_W*BURST_LEN/8 = 32 bytes)
//  LINES       256  backing-store depth in lines (power of 2)
//  READ_LAT    8    cycles from request sample to first read beat (>=1)
//  WRITE_LAT   8    cycles from request sample to first write beat (>=1)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous active-high reset
//  mem_read     in   1       read request, held until final beat
//  mem_write    in   1       write request, held until final beat
//  mem_addr     in   32      byte address, held stable for whole request
//  mem_wdata    in   DATA_W  write beat, advanced by initiator after each mem_resp
//  mem_rdata    out  DATA_W  read beat, valid only while mem_resp=1
//  mem_resp     out  1       beat strobe, one per beat, BURST_LEN per request
//  busy         out  1       high in every state except IDLE
//  err          out  1       sticky protocol-error flag
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high (clk/rst). Outputs mem_resp=0, mem_rdata=0, busy=0, err=0; FSM->IDLE; counters=0.
//   Backing array is NOT reset. Reset mid-burst aborts immediately; a partially written line keeps beats already written.
//  Indexing: line = mem_addr[5 +: log2(LINES)] (wraps modulo LINES); addr[2:0] ignored.
//  FSM: IDLE -> WAIT -> BURST -> DONE -> IDLE.
//   IDLE:  read xor write sampled high -> latch op/addr, load lat_cnt=LAT-1, go WAIT.
//          read&write both high -> err<=1, stay IDLE, no response.
//   WAIT:  lat_cnt decrements; at 0 go BURST. Request dropped -> IDLE, no beats.
//   BURST: mem_resp=1 each cycle for BURST_LEN consecutive cycles, beat_cnt 0..BURST_LEN-1.
//          read: mem_rdata = array[line][beat] combinationally from registered index.
//          write: mem_wdata captured into array[line][beat] at the edge ending each resp cycle.
//          After last beat -> DONE.
//   DONE:  one cycle, mem_resp=0, request inputs ignored (initiator deasserts here).
//  Latency: request first high in cycle c -> first mem_resp in cycle c+LAT; last in c+LAT+BURST_LEN-1; next request sampled no earlier than c+LAT+BURST_LEN+1.
//  Protocol checks (set err, sticky until rst):
//   - mem_addr differs from latched address in WAIT/BURST.
//   - request deasserted or op switched during BURST; burst still completes, writes still committed.
//  mem_rdata = 0 whenever mem_resp=0.
//  Read-after-write to same line returns new data (write fully committed before DONE).
// CONFIGURATION
//  BURST_WRAP_EN defined:
//   - Critical-word-first: beat k addresses word (addr[4:3]+k) mod BURST_LEN, wrapping 3->0.
//   - Write beats are stored at the same wrapped order.
//  BURST_WRAP_EN undefined:
//   - Beats always ordered 0..BURST_LEN-1; addr[4:3] ignored.
// TESTING
//  1. rst high 2 cycles mid-BURST -> next cycle mem_resp=0, busy=0, err=0; following read of same line returns unaffected beats.
//  2. Write addr 0x0000_0040, beats 0x11..,0x22..,0x33..,0x44..; then read 0x40 -> same 4 beats in order; first resp exactly READ_LAT=8 cycles after sample.
//  3. Read addr 0x0000_2040 with LINES=256 -> aliases line 2 (same data as 0x40).
//  4. BURST_WRAP_EN defined, read 0x58 (addr[4:3]=3) -> beats in word order 3,0,1,2; undefined -> 0,1,2,3.
//  5. mem_read&mem_write both high in IDLE -> err=1, no mem_resp for 20 cycles; err holds until rst.
//  6. Drop mem_read at WAIT cycle 3 -> no beats, busy=0 next cycle, err=0; addr change in BURST -> err=1, burst completes 4 beats.

Source files
------------

// File: rtl/burst_mem_responder.sv
// Burst memory responder: serves BURST_LEN x DATA_W beats per line READ_LAT/WRITE_LAT cycles after the request is sampled.
// No backpressure: the initiator holds the request until the final mem_resp. err is sticky on protocol misuse.
// Optional BURST_WRAP_EN: critical-word-first beat ordering starting at addr[4:3].
module burst_mem_responder #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int LINES     = 256,
    parameter int READ_LAT  = 8,
    parameter int WRITE_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              busy,
    output logic              err
);
    localparam int LINE_W = $clog2(LINES);
    localparam int WORD_W = $clog2(BURST_LEN);
    localparam int WOFF   = $clog2(DATA_W / 8);
    localparam int LOFF   = $clog2(DATA_W * BURST_LEN / 8);
    localparam int LAT_W  = 16;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t              state, state_nxt;
    logic [31:0]         addr_q;
    logic                op_wr_q;
    logic [LAT_W-1:0]    lat_cnt;
    logic [WORD_W-1:0]   beat_cnt;
    logic [LAT_W-1:0]    first_lat;
    logic                accept, err_set;
    logic                req_held, req_other;
    logic [WORD_W-1:0]   word;
    logic [LINE_W-1:0]   line;
    logic [DATA_W-1:0]   store [LINES*BURST_LEN];

    assign first_lat = mem_write ? LAT_W'(WRITE_LAT) : LAT_W'(READ_LAT);
    assign req_held  = op_wr_q ? mem_write : mem_read;
    assign req_other = op_wr_q ? mem_read  : mem_write;
    assign line      = addr_q[LOFF +: LINE_W];

`ifdef BURST_WRAP_EN
    assign word = addr_q[WOFF +: WORD_W] + beat_cnt;
`else
    assign word = beat_cnt;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_set = 1'b1;
                end else if (mem_read || mem_write) begin
                    accept    = 1'b1;
                    state_nxt = (first_lat == LAT_W'(1)) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else begin
                    if (mem_addr != addr_q) err_set = 1'b1;
                    // Counter reaches zero on this edge.
                    if (lat_cnt == LAT_W'(1)) state_nxt = BURST;
                end
            end
            BURST: begin
                if (mem_addr != addr_q || !req_held || req_other) err_set = 1'b1;
                if (beat_cnt == WORD_W'(BURST_LEN - 1)) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            op_wr_q  <= 1'b0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) err <= 1'b1;
            if (accept) begin
                addr_q  <= mem_addr;
                op_wr_q <= mem_write;
                lat_cnt <= first_lat - LAT_W'(1);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (state == BURST) beat_cnt <= beat_cnt + WORD_W'(1);
            else                beat_cnt <= '0;
        end
    end

    // Backing store is deliberately not reset; a reset edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == BURST && op_wr_q)
            store[{line, word}] <= mem_wdata;
    end

    assign mem_resp  = (state == BURST);
    assign busy      = (state != IDLE);
    assign mem_rdata = (state == BURST && !op_wr_q) ? store[{line, word}] : '0;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: latency, data, aliasing, beat order, reset abort, protocol errors.
module tb_burst_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [63:0] mem_rdata;
    logic        mem_resp;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wbeat [4];
    logic [63:0] rbeat [4];
    logic [63:0] a_dat [4];
    logic [63:0] b_dat [4];
    logic [63:0] c_dat [4];
    logic [63:0] d_dat [4];
    int ord [4];
    int nb, lat;

    burst_mem_responder dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from a negedge and samples beats at negedges.
    // rst_after>0: reset for 2 cycles in the cycle after that many beats were seen.
    // drop_at>0: request removed at that cycle offset. chg_at>0: address changed at that offset.
    task automatic xfer(input bit wr, input logic [31:0] addr, input int rst_after,
                        input int drop_at, input int chg_at, output int nbeats, output int first);
        int cyc = 0;
        int n = 0;
        bit stop = 1'b0;
        first = -1;
        @(negedge clk);
        mem_read = !wr; mem_write = wr; mem_addr = addr; mem_wdata = wbeat[0];
        while (n < 4 && cyc < 60 && !stop) begin
            @(negedge clk);
            cyc++;
            if (rst_after > 0 && n == rst_after) begin
                rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                stop = 1'b1;
            end else begin
                if (drop_at > 0 && cyc == drop_at) begin
                    mem_read = 1'b0; mem_write = 1'b0;
                end
                if (drop_at > 0 && cyc == drop_at + 1) chk("drop_busy_next", 64'(busy), 64'd0);
                if (chk_at_ok(chg_at, cyc)) mem_addr = addr ^ 32'h0000_0100;
                if (n < 4) mem_wdata = wbeat[n];
                if (mem_resp) begin
                    if (n == 0) first = cyc;
                    rbeat[n] = mem_rdata;
                    n++;
                end
            end
        end
        nbeats = n;
        if (!stop && n == 4) begin
            @(negedge clk);
            chk("done_resp_busy", {62'd0, mem_resp, busy}, 64'd1);
            chk("done_rdata_zero", mem_rdata, 64'd0);
            mem_read = 1'b0; mem_write = 1'b0; mem_addr = addr;
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = addr;
    endtask

    function automatic bit chk_at_ok(input int at, input int cyc);
        return at > 0 && cyc == at;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_dat[i] = {4{16'h1111 * 16'(i + 1)}};
            b_dat[i] = 64'hB0B0_0000_0000_0000 | 64'(i * 7 + 3);
            c_dat[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 16'h100);
            d_dat[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i + 5);
        end
`ifdef BURST_WRAP_EN
        ord = '{3, 0, 1, 2};
`else
        ord = '{0, 1, 2, 3};
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp", 64'(mem_resp), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);

        // Write line 0x40 then read it back
        wbeat = a_dat;
        xfer(1'b1, 32'h0000_0040, 0, 0, 0, nb, lat);
        chk("wr40_beats", 64'(nb), 64'd4);
        chk("wr40_lat", 64'(lat), 64'd8);
        xfer(1'b0, 32'h0000_0040, 0, 0, 0, nb, lat);
        chk("rd40_beats", 64'(nb), 64'd4);
        chk("rd40_lat", 64'(lat), 64'd8);
        for (int i = 0; i < 4; i++) chk($sformatf("rd40_b%0d", i), rbeat[i], a_dat[i]);

        // Alias: 0x2040 maps to line 2 with 256 lines
        xfer(1'b0, 32'h0000_2040, 0, 0, 0, nb, lat);
        for (int i = 0; i < 4; i++) chk($sformatf("rd2040_b%0d", i), rbeat[i], a_dat[i]);

        // Beat ordering from a word-3 address
        wbeat = b_dat;
        xfer(1'b1, 32'h0000_0080, 0, 0, 0, nb, lat);
        xfer(1'b0, 32'h0000_0098, 0, 0, 0, nb, lat);
        for (int i = 0; i < 4; i++) chk($sformatf("rd98_b%0d", i), rbeat[i], b_dat[ord[i]]);
        chk("clean_err", 64'(err), 64'd0);

        // Reset mid read burst
        wbeat = c_dat;
        xfer(1'b1, 32'h0000_00C0, 0, 0, 0, nb, lat);
        xfer(1'b0, 32'h0000_00C0, 2, 0, 0, nb, lat);
        chk("rstmid_resp", 64'(mem_resp), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_err", 64'(err), 64'd0);
        xfer(1'b0, 32'h0000_00C0, 0, 0, 0, nb, lat);
        for (int i = 0; i < 4; i++) chk($sformatf("rdC0_b%0d", i), rbeat[i], c_dat[i]);

        // Reset mid write burst: beats already written persist, untouched beat keeps old data
        wbeat = d_dat;
        xfer(1'b1, 32'h0000_00C0, 2, 0, 0, nb, lat);
        xfer(1'b0, 32'h0000_00C0, 0, 0, 0, nb, lat);
        chk("wrpart_b0", rbeat[0], d_dat[0]);
        chk("wrpart_b1", rbeat[1], d_dat[1]);
        chk("wrpart_b3", rbeat[3], c_dat[3]);

        // Request dropped during WAIT
        xfer(1'b0, 32'h0000_0040, 0, 3, 0, nb, lat);
        chk("drop_beats", 64'(nb), 64'd0);
        chk("drop_err", 64'(err), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);

        // Address change during BURST
        xfer(1'b0, 32'h0000_0040, 0, 0, 9, nb, lat);
        chk("achg_beats", 64'(nb), 64'd4);
        chk("achg_err", 64'(err), 64'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("achg_b%0d", i), rbeat[i], a_dat[i]);

        // Reset clears err
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_err", 64'(err), 64'd0);

        // Read and write together in IDLE
        begin
            int resp_seen = 0;
            mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h0000_0040;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_resp) resp_seen++;
            end
            chk("both_resp", 64'(resp_seen), 64'd0);
            chk("both_err", 64'(err), 64'd1);
            chk("both_busy", 64'(busy), 64'd0);
            mem_read = 1'b0; mem_write = 1'b0;
            repeat (5) @(negedge clk);
            chk("both_err_hold", 64'(err), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("both_err_clr", 64'(err), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
